// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with registered
// predictions, and a mispredict redirect followed by a fixed-length flush window.
module branch_predictor #(
  parameter int ENTRIES      = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_imm,
  output logic        pred_out_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_imm,
  input  logic [2:0]  res_fun3,
  input  logic        res_taken,
  input  logic        res_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  localparam int         IDXW       = $clog2(ENTRIES);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [2:0]      fcnt_r, fcnt_s;
  logic [1:0]      ctr_r [ENTRIES];
  logic [IDXW-1:0] pidx_s, ridx_s;
  logic [1:0]      ctr_rd_s, ctr_next_s;
  logic            legal_s;
  logic            pov_s, ptaken_s, rv_s, flush_s;
  logic [31:0]     ptarget_s, rpc_s;

  // Next-state, next-output and counter-update logic.
  always_comb begin
    state_s    = state_r;
    fcnt_s     = fcnt_r;
    pidx_s     = pred_pc[IDXW+1:2];
    ridx_s     = res_pc[IDXW+1:2];
    ctr_rd_s   = ctr_r[ridx_s];
    ctr_next_s = ctr_rd_s;
    legal_s    = 1'b0;
    pov_s      = 1'b0;
    ptaken_s   = 1'b0;
    ptarget_s  = 32'd0;
    rv_s       = 1'b0;
    rpc_s      = 32'd0;
    case (state_r)
      RUN: begin
        if (pred_valid) begin
          pov_s     = 1'b1;
          ptaken_s  = ctr_r[pidx_s][1];
          ptarget_s = ptaken_s ? (pred_pc + pred_imm) : (pred_pc + 32'd4);
        end else begin
          pov_s = 1'b0;
        end
        // funct3 010/011 are not branch encodings; res_taken is meaningless there.
        if (res_valid && (res_fun3 != 3'b010) && (res_fun3 != 3'b011)) begin
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
        if (legal_s && (res_taken != res_pred_taken)) begin
          state_s = FLUSH;
          fcnt_s  = FLUSH_LOAD;
          rv_s    = 1'b1;
          rpc_s   = res_taken ? (res_pc + res_imm) : (res_pc + 32'd4);
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (fcnt_r == 3'd0) begin
          state_s = RUN;
        end else begin
          fcnt_s = fcnt_r - 3'd1;
        end
      end
      default: begin
        state_s = RUN;
        fcnt_s  = 3'd0;
      end
    endcase
    flush_s = (state_s == FLUSH);
    if (legal_s) begin
      if (res_taken) begin
        ctr_next_s = (ctr_rd_s == 2'b11) ? ctr_rd_s : (ctr_rd_s + 2'b01);
      end else begin
        ctr_next_s = (ctr_rd_s == 2'b00) ? ctr_rd_s : (ctr_rd_s - 2'b01);
      end
    end else begin
      ctr_next_s = ctr_rd_s;
    end
  end

  // FSM state and flush-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      fcnt_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
    end else begin
      pred_out_valid <= pov_s;
      pred_taken     <= ptaken_s;
      pred_target    <= ptarget_s;
      redirect_valid <= rv_s;
      redirect_pc    <= rpc_s;
      flush          <= flush_s;
    end
  end

  // Counter table; the prediction read above sees the pre-update value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (legal_s) begin
      ctr_r[ridx_s] <= ctr_next_s;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: each step pushes the expected
// registered outputs to a scoreboard, which is popped and compared after the edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc, pred_imm;
  logic        pred_out_valid, pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc, res_imm;
  logic [2:0]  res_fun3;
  logic        res_taken, res_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        pov;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  branch_predictor #(.ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_imm(pred_imm),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_imm(res_imm), .res_fun3(res_fun3),
    .res_taken(res_taken), .res_pred_taken(res_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // One clock of stimulus; expected outputs become visible after this edge.
  task automatic step(input string tag,
                      input logic pv, input logic [31:0] ppc, input logic [31:0] pimm,
                      input logic resv, input logic [31:0] rpc_i, input logic [31:0] rimm,
                      input logic [2:0] f3, input logic rt, input logic rpt,
                      input logic e_pov, input logic e_pt, input logic [31:0] e_ptgt,
                      input logic e_rv, input logic [31:0] e_rpc, input logic e_fl);
    exp_t  e;
    string t;
    pred_valid = pv;  pred_pc = ppc;  pred_imm = pimm;
    res_valid = resv; res_pc = rpc_i; res_imm = rimm; res_fun3 = f3;
    res_taken = rt;   res_pred_taken = rpt;
    sb.push_back('{e_pov, e_pt, e_ptgt, e_rv, e_rpc, e_fl});
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    t = sb_tag.pop_front();
    chk(t, "pred_out_valid", {31'd0, pred_out_valid}, {31'd0, e.pov});
    chk(t, "pred_taken",     {31'd0, pred_taken},     {31'd0, e.pt});
    chk(t, "pred_target",    pred_target,             e.ptgt);
    chk(t, "redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
    chk(t, "redirect_pc",    redirect_pc,             e.rpc);
    chk(t, "flush",          {31'd0, flush},          {31'd0, e.fl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    //     tag            pv  ppc           pimm   rv  rpc          rimm          f3      rt    rpt   pov  pt   ptgt          rv   rpc    fl
    step("reset0",       0, 32'h0,        32'h0,  0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 0,   0,   32'h0,        0,   32'h0, 0);
    step("reset1",       1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 0,   0,   32'h0,        0,   32'h0, 0);
    reset = 1'b0;
    step("pred_init",    1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   0,   32'h104,      0,   32'h0, 0);
    // Same-cycle predict+update at 0x100: prediction sees the old counter (01).
    step("rbw_1",        1, 32'h100,      32'h20, 1, 32'h100,     32'h20,       3'b000, 1'b1, 1'b1, 1,   0,   32'h104,      0,   32'h0, 0);
    step("rbw_2",        1, 32'h100,      32'h20, 1, 32'h100,     32'h20,       3'b001, 1'b1, 1'b1, 1,   1,   32'h120,      0,   32'h0, 0);
    step("sat_upd",      1, 32'h100,      32'h20, 1, 32'h100,     32'h20,       3'b100, 1'b1, 1'b1, 1,   1,   32'h120,      0,   32'h0, 0);
    step("sat_pred",     1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   1,   32'h120,      0,   32'h0, 0);
    // One correct not-taken update: saturated 3 drops to 2, still taken.
    step("sat_dec",      0, 32'h0,        32'h0,  1, 32'h100,     32'h20,       3'b000, 1'b0, 1'b0, 0,   0,   32'h0,        0,   32'h0, 0);
    step("sat_chk",      1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   1,   32'h120,      0,   32'h0, 0);
    step("wrap_upd1",    0, 32'h0,        32'h0,  1, 32'hFFFFFFFC, 32'h8,       3'b101, 1'b1, 1'b1, 0,   0,   32'h0,        0,   32'h0, 0);
    step("wrap_upd2",    0, 32'h0,        32'h0,  1, 32'hFFFFFFFC, 32'h8,       3'b110, 1'b1, 1'b1, 0,   0,   32'h0,        0,   32'h0, 0);
    step("wrap_pred",    1, 32'hFFFFFFFC, 32'h8,  0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   1,   32'h4,        0,   32'h0, 0);
    // Non-branch funct3: no update, no redirect even though rt and rpt disagree.
    step("illegal_010",  0, 32'h0,        32'h0,  1, 32'hFFFFFFFC, 32'h8,       3'b010, 1'bx, 1'b1, 0,   0,   32'h0,        0,   32'h0, 0);
    step("illegal_011",  0, 32'h0,        32'h0,  1, 32'hFFFFFFFC, 32'h8,       3'b011, 1'bx, 1'b1, 0,   0,   32'h0,        0,   32'h0, 0);
    step("illegal_chk",  1, 32'hFFFFFFFC, 32'h8,  0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   1,   32'h4,        0,   32'h0, 0);
    // Mispredict at 0x200 (index 0, counter 2 -> 3), taken backwards.
    step("mis_pulse",    0, 32'h0,        32'h0,  1, 32'h200,     32'hFFFFFFF0, 3'b000, 1'b1, 1'b0, 0,   0,   32'h0,        1,   32'h1F0, 1);
    step("mis_flush1",   1, 32'h100,      32'h20, 1, 32'h100,     32'h20,       3'b000, 1'b0, 1'b1, 0,   0,   32'h0,        0,   32'h0, 1);
    step("mis_flush2",   1, 32'h100,      32'h20, 1, 32'h100,     32'h20,       3'b000, 1'b0, 1'b1, 0,   0,   32'h0,        0,   32'h0, 0);
    step("mis_after",    1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   1,   32'h120,      0,   32'h0, 0);
    // Not-taken mispredict, then reset during the first flush cycle.
    step("mis2_pulse",   0, 32'h0,        32'h0,  1, 32'h200,     32'h10,       3'b000, 1'b0, 1'b1, 0,   0,   32'h0,        1,   32'h204, 1);
    reset = 1'b1;
    step("rst_mid",      1, 32'h100,      32'h20, 1, 32'h200,     32'h10,       3'b000, 1'b1, 1'b0, 0,   0,   32'h0,        0,   32'h0, 0);
    reset = 1'b0;
    step("rst_pred0",    1, 32'h100,      32'h20, 0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   0,   32'h104,      0,   32'h0, 0);
    step("rst_predF",    1, 32'hFFFFFFFC, 32'h8,  0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 1,   0,   32'h0,        0,   32'h0, 0);
    step("idle",         0, 32'h0,        32'h0,  0, 32'h0,       32'h0,        3'b000, 1'b0, 1'b0, 0,   0,   32'h0,        0,   32'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
